// File: rtl/encode_mul_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared pipelined signed multiplier and routes tagged results back.
// ENCODE_MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module encode_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 40,
  parameter int B_WIDTH = 22,
  parameter int P_WIDTH = 61,
  parameter int MUL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_data
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [MUL_LAT-1:0] vld_pipe;
  logic [ID_W-1:0]    id_pipe [MUL_LAT];
  logic [ID_W-1:0]    rr_ptr;
  logic               stall;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;

  assign stall  = vld_pipe[MUL_LAT-1] & ~rsp_ready[id_pipe[MUL_LAT-1]];
  assign mul_ce = ~stall;

  // Rotating search starting at rr_ptr; first valid requester in that order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!stall && !reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0 = req_a[grant_idx*A_WIDTH +: A_WIDTH];
      mul_din1 = req_b[grant_idx*B_WIDTH +: B_WIDTH];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = vld_pipe[MUL_LAT-1] && (id_pipe[MUL_LAT-1] == ID_W'(i));
    end
  end

  assign rsp_data = mul_dout;

  // Tag pipe mirrors the multiplier's ce-gated registers so tags stay aligned with dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        id_pipe[k] <= '0;
      end
    end else if (!stall) begin
      vld_pipe[0] <= grant_found;
      id_pipe[0]  <= grant_idx;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_encode_mul_arbiter.sv
// Directed table-driven bench for encode_mul_arbiter with a behavioural ce-gated multiplier.
// Second instance with MUL_LAT=3 covers reset during in-flight operations.
module tb_encode_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MUL_LAT=1 instance
  logic          reset = 1'b1;
  logic [3:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [159:0]  req_a = '0;
  logic [87:0]   req_b = '0;
  logic          mul_ce;
  logic [39:0]   mul_din0;
  logic [21:0]   mul_din1;
  logic [60:0]   mul_dout, rsp_data;

  // MUL_LAT=3 instance
  logic          reset3 = 1'b1;
  logic [3:0]    req_valid3 = '0, req_ready3, rsp_valid3, rsp_ready3 = '1;
  logic [159:0]  req_a3 = '0;
  logic [87:0]   req_b3 = '0;
  logic          mul_ce3;
  logic [39:0]   mul_din0_3;
  logic [21:0]   mul_din1_3;
  logic [60:0]   mul_dout3, rsp_data3;

  encode_mul_arbiter #(.NUM_REQ(4), .A_WIDTH(40), .B_WIDTH(22), .P_WIDTH(61), .MUL_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data));

  encode_mul_arbiter #(.NUM_REQ(4), .A_WIDTH(40), .B_WIDTH(22), .P_WIDTH(61), .MUL_LAT(3)) u3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .mul_ce(mul_ce3), .mul_din0(mul_din0_3),
    .mul_din1(mul_din1_3), .mul_dout(mul_dout3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3));

  function automatic logic [60:0] prod(input logic signed [39:0] x, input logic signed [21:0] y);
    logic signed [61:0] f;
    f = x * y;
    return f[60:0];
  endfunction

  logic [60:0] m1_q;
  logic [60:0] m3_q [3];
  always_ff @(posedge clk) if (mul_ce) m1_q <= prod(mul_din0, mul_din1);
  always_ff @(posedge clk) begin
    if (mul_ce3) begin
      m3_q[0] <= prod(mul_din0_3, mul_din1_3);
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
    end
  end
  assign mul_dout  = m1_q;
  assign mul_dout3 = m3_q[2];

  logic seen3 = 1'b0;
  always @(negedge clk) if (|rsp_valid3) seen3 = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  typedef struct {
    logic              rst;
    logic [3:0]        valid;
    logic [3:0]        rready;
    logic signed [39:0] a;
    logic signed [21:0] b;
    logic [3:0]        exp_ready;
    logic              exp_ce;
    logic [3:0]        exp_rvalid;
    logic [60:0]       exp_data;
  } vec_t;

  vec_t vecs[$];

  // Requester i gets operands (a - i, b).
  task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] rr,
                     input logic signed [39:0] a, input logic signed [21:0] b,
                     input logic [3:0] er, input logic ece, input logic [3:0] erv,
                     input logic [60:0] ed);
    vec_t r;
    r.rst = rst; r.valid = v; r.rready = rr; r.a = a; r.b = b;
    r.exp_ready = er; r.exp_ce = ece; r.exp_rvalid = erv; r.exp_data = ed;
    vecs.push_back(r);
  endtask

  initial begin
    // reset, then single transfer 3 * -5
    add(1, 4'b1111, 4'b1111, 40'sd0, 22'sd0, 4'b0000, 1, 4'b0000, 61'd0);
    add(0, 4'b0001, 4'b1111, 40'sd3, -22'sd5, 4'b0001, 1, 4'b0000, 61'd0);
    add(0, 4'b0000, 4'b1111, 40'sd3, -22'sd5, 4'b0000, 1, 4'b0001, -61'sd15);
    add(1, 4'b0000, 4'b1111, 40'sd0, 22'sd0, 4'b0000, 1, 4'b0000, 61'd0);
    // all requesting, products 28,21,14,7
`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0000, 61'd0);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0001, 61'd28);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0001, 61'd28);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0001, 61'd28);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0001, 61'd28);
    add(0, 4'b0000, 4'b1111, 40'sd4, 22'sd7, 4'b0000, 1, 4'b0001, 61'd28);
`else
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b0000, 61'd0);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0010, 1, 4'b0001, 61'd28);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0100, 1, 4'b0010, 61'd21);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b1000, 1, 4'b0100, 61'd14);
    add(0, 4'b1111, 4'b1111, 40'sd4, 22'sd7, 4'b0001, 1, 4'b1000, 61'd7);
    add(0, 4'b0000, 4'b1111, 40'sd4, 22'sd7, 4'b0000, 1, 4'b0001, 61'd28);
`endif
    // extreme operands on requester 1: (-2^39) * (-2^21) = 2^60
    add(0, 4'b0010, 4'b1111, -40'sd549755813887, 22'sh200000, 4'b0010, 1, 4'b0000, 61'd0);
    add(0, 4'b0000, 4'b1111, -40'sd549755813887, 22'sh200000, 4'b0000, 1, 4'b0010, 61'h1000_0000_0000_0000);
    // backpressure on requester 2 (product 9) for 3 cycles
    add(0, 4'b0100, 4'b1111, 40'sd5, 22'sd3, 4'b0100, 1, 4'b0000, 61'd0);
    add(0, 4'b1011, 4'b1011, 40'sd5, 22'sd3, 4'b0000, 0, 4'b0100, 61'd9);
    add(0, 4'b1011, 4'b1011, 40'sd5, 22'sd3, 4'b0000, 0, 4'b0100, 61'd9);
    add(0, 4'b1011, 4'b1011, 40'sd5, 22'sd3, 4'b0000, 0, 4'b0100, 61'd9);
`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
    add(0, 4'b1011, 4'b1111, 40'sd5, 22'sd3, 4'b0001, 1, 4'b0100, 61'd9);
    add(0, 4'b0000, 4'b1111, 40'sd5, 22'sd3, 4'b0000, 1, 4'b0001, 61'd15);
`else
    add(0, 4'b1011, 4'b1111, 40'sd5, 22'sd3, 4'b1000, 1, 4'b0100, 61'd9);
    add(0, 4'b0000, 4'b1111, 40'sd5, 22'sd3, 4'b0000, 1, 4'b1000, 61'd6);
`endif
    // pointer wrap after requester 3; products -2,-1,0,1
    add(0, 4'b0100, 4'b1111, 40'sd2, -22'sd1, 4'b0100, 1, 4'b0000, 61'd0);
`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
    add(0, 4'b1111, 4'b1111, 40'sd2, -22'sd1, 4'b0001, 1, 4'b0100, 61'd0);
    add(0, 4'b0101, 4'b1111, 40'sd2, -22'sd1, 4'b0001, 1, 4'b0001, -61'sd2);
    add(0, 4'b0101, 4'b1111, 40'sd2, -22'sd1, 4'b0001, 1, 4'b0001, -61'sd2);
    add(0, 4'b0000, 4'b1111, 40'sd2, -22'sd1, 4'b0000, 1, 4'b0001, -61'sd2);
`else
    add(0, 4'b1111, 4'b1111, 40'sd2, -22'sd1, 4'b1000, 1, 4'b0100, 61'd0);
    add(0, 4'b0101, 4'b1111, 40'sd2, -22'sd1, 4'b0001, 1, 4'b1000, 61'd1);
    add(0, 4'b0101, 4'b1111, 40'sd2, -22'sd1, 4'b0100, 1, 4'b0001, -61'sd2);
    add(0, 4'b0000, 4'b1111, 40'sd2, -22'sd1, 4'b0000, 1, 4'b0100, 61'd0);
`endif

    foreach (vecs[r]) begin
      @(negedge clk);
      reset     = vecs[r].rst;
      req_valid = vecs[r].valid;
      rsp_ready = vecs[r].rready;
      for (int i = 0; i < 4; i++) begin
        req_a[i*40 +: 40] = vecs[r].a - 40'(i);
        req_b[i*22 +: 22] = vecs[r].b;
      end
      #1;
      check("req_ready", r, 64'(req_ready), 64'(vecs[r].exp_ready));
      check("rsp_valid", r, 64'(rsp_valid), 64'(vecs[r].exp_rvalid));
      if (!vecs[r].rst) check("mul_ce", r, 64'(mul_ce), 64'(vecs[r].exp_ce));
      if (!vecs[r].rst && vecs[r].exp_rvalid != 4'b0000)
        check("rsp_data", r, 64'(rsp_data), 64'(vecs[r].exp_data));
    end

    // MUL_LAT=3: two issues in flight, reset lands before any result emerges
    for (int i = 0; i < 4; i++) begin
      req_a3[i*40 +: 40] = 40'(i + 1);
      req_b3[i*22 +: 22] = 22'sd3;
    end
    @(negedge clk);
    reset3 = 1'b0; req_valid3 = 4'b1111; rsp_ready3 = 4'b1111;
    #1 check("lat3_grant0", 100, 64'(req_ready3), 64'(4'b0001));
    @(negedge clk);
    #1 check("lat3_grant1", 101, 64'(req_ready3), 64'(4'b0010));
    @(negedge clk);
    #1 check("lat3_grant2", 102, 64'(req_ready3), 64'(4'b0100));
    reset3 = 1'b1;
    #1 check("lat3_rst_ready", 103, 64'(req_ready3), 64'(4'b0000));
    check("lat3_rst_rvalid", 103, 64'(rsp_valid3), 64'(4'b0000));
    repeat (2) @(negedge clk);
    reset3 = 1'b0;
    #1 check("lat3_post_grant", 104, 64'(req_ready3), 64'(4'b0001));
    req_valid3 = 4'b0000;
    repeat (5) @(negedge clk);
    #1 check("lat3_no_rsp", 105, 64'(seen3), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
